ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM pipeline boundary of the RISC-V core, directly downstream of the ALU. Registers the ALU result, destination register and memory/writeback controls, with stall and flush support. Generates store byte lanes and byte enables from `funct3` and the ALU-computed address. Detects misaligned accesses and keeps a count of instructions passed to MEM.

## Interface
Parameters:
- `DATA_WIDTH`, 32: datapath width. Only 32 is supported for lane logic.
- `REG_ADDR`, 5: register index width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `in_valid`  in  1  EX holds a real instruction.
- `stall`  in  1  hold all registered state.
- `flush`  in  1  insert a bubble.
- `alu_result`  in  DATA_WIDTH  ALU output; this is the address for loads and stores.
- `rs2_data`  in  DATA_WIDTH  store data.
- `rd`  in  REG_ADDR  destination register.
- `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`  in  1 each  controls.
- `funct3`  in  3  access size and signedness.
- `out_valid`  out  1  MEM holds a real instruction.
- `out_alu_result`  out  DATA_WIDTH  registered `alu_result`, unmodified.
- `out_rd`  out  REG_ADDR  registered `rd`.
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_mem_to_reg`  out  1 each  registered controls.
- `out_funct3`  out  3  registered `funct3`.
- `out_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `out_byte_en`  out  4  byte enables.
- `out_misaligned`  out  1  the registered access was misaligned.
- `retired_cnt`  out  32  valid instructions accepted into MEM.

## Operation
Priority on each edge: reset, then flush, then stall, then load.
- Reset (`reset`=0): every output is 0, including `retired_cnt`.
- Flush: `out_valid` and all `out_*` controls, `out_byte_en` and `out_misaligned` go to 0. Data outputs go to 0. `retired_cnt` holds. Flush wins over a simultaneous stall.
- Stall: every output holds its value, including `retired_cnt`.
- Load: all outputs capture their inputs. `retired_cnt` increments by 1 when `in_valid`=1 and wraps from 0xFFFFFFFF to 0.
- Load with `in_valid`=0: same as flush, except `retired_cnt` is also unchanged.

Lane generation uses `a = alu_result[1:0]` and `funct3[1:0]`:
- 00, byte: `wdata = {4{rs2[7:0]}}`, `be = 4'b0001 << a`.
- 01, half: `wdata = {2{rs2[15:0]}}`, `be = 4'b0011 << {a[1],1'b0}`.
- 10, word: `wdata = rs2`, `be = 4'b1111`.
- 11: illegal.
- `be` is forced to 0 unless `mem_read | mem_write`.
- `funct3[2]` (unsigned load) does not affect `be`. It is passed through only.

Misalignment is defined only for memory accesses (`mem_read | mem_write`):
- half with `a[0]=1`;
- word with `a != 0`;
- `funct3[1:0]`=11.

## Timing
- Latency is 1 cycle: inputs present at edge N appear on outputs after edge N.
- All outputs are registered. There are no combinational input-to-output paths.
- Releasing `stall` loads the current inputs on the next edge.
- If reset is asserted mid-stall or mid-flush, reset wins on that edge.

## Configuration
Macro `EX_MEM_MISALIGN_TRAP_EN`.

Defined:
- A misaligned access is squashed on load: `out_mem_read`, `out_mem_write`, `out_reg_write` and `out_byte_en` are forced to 0.
- `out_misaligned`=1 and `out_valid` follows `in_valid`.
- `retired_cnt` still increments.

Undefined:
- No squash. Addresses are aligned down for lane generation: half ignores `a[0]`, word ignores `a`.
- `funct3[1:0]`=11 is treated as word.
- `out_misaligned` is tied to 0.
- `out_alu_result` is unmodified in both builds.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with nonzero inputs -> all outputs 0 and `retired_cnt`=0.
- Store byte: `alu_result`=0x1003, `rs2`=0x000000AB, `mem_write`=1, `funct3`=000 -> `out_wdata`=0xABABABAB, `out_byte_en`=4'b1000, one cycle later.
- Store half: `alu_result`=0x2002, `rs2`=0x1234, `funct3`=001 -> `out_wdata`=0x12341234, `out_byte_en`=4'b1100.
- Stall/flush: load `rd`=5 and `in_valid`=1; then `stall`=1 for 3 cycles with changing inputs -> outputs hold `rd`=5. Then `stall`=1 and `flush`=1 -> `out_valid`=0, `out_reg_write`=0, `retired_cnt` unchanged.
- Misaligned word load at 0x1001, macro defined -> `out_misaligned`=1, `out_mem_read`=0, `out_byte_en`=0. Macro undefined -> `out_byte_en`=4'b1111, `out_misaligned`=0.
- Counter wrap: force `retired_cnt` to 0xFFFFFFFF and load a valid instruction -> 0x00000000. Load with `in_valid`=0 -> stays 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: registers ALU result and controls, builds store lanes/byte enables,
// flags misaligned accesses and counts retired instructions. Optional trap build: EX_MEM_MISALIGN_TRAP_EN.
module ex_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [REG_ADDR-1:0]   rd,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic [2:0]            funct3,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_alu_result,
    output logic [REG_ADDR-1:0]   out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_mem_to_reg,
    output logic [2:0]            out_funct3,
    output logic [DATA_WIDTH-1:0] out_wdata,
    output logic [3:0]            out_byte_en,
    output logic                  out_misaligned,
    output logic [31:0]           retired_cnt
);

    // Byte enables for an access of the given size at byte offset a (size 11 handled as word).
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                         input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            2'b10:   w = d;
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            2'b10:   m = (a != 2'b00);
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    logic                  mem_acc_s;
    logic [3:0]            be_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic                  mis_s;
    logic                  squash_s;
    logic                  bubble_s;
    logic [31:0]           cnt_r;

    // Lane generation and misalignment detection for the instruction currently in EX.
    always_comb begin
        mem_acc_s = mem_read | mem_write;
        wdata_s   = lane_wdata(funct3[1:0], rs2_data);
        if (mem_acc_s) begin
            be_s = lane_be(funct3[1:0], alu_result[1:0]);
        end else begin
            be_s = 4'b0000;
        end
`ifdef EX_MEM_MISALIGN_TRAP_EN
        mis_s    = mem_acc_s & is_misaligned(funct3[1:0], alu_result[1:0]);
        squash_s = mis_s;
`else
        mis_s    = 1'b0;
        squash_s = 1'b0;
`endif
        bubble_s = flush | (~stall & ~in_valid);
    end

    // Pipeline register: reset, then flush/bubble, then stall (hold), then load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid      <= 1'b0;
            out_alu_result <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_funct3     <= 3'b000;
            out_wdata      <= '0;
            out_byte_en    <= 4'b0000;
            out_misaligned <= 1'b0;
            cnt_r          <= 32'h0000_0000;
        end else if (bubble_s) begin
            out_valid      <= 1'b0;
            out_alu_result <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_funct3     <= 3'b000;
            out_wdata      <= '0;
            out_byte_en    <= 4'b0000;
            out_misaligned <= 1'b0;
        end else if (!stall) begin
            out_valid      <= in_valid;
            out_alu_result <= alu_result;
            out_rd         <= rd;
            out_reg_write  <= reg_write & ~squash_s;
            out_mem_read   <= mem_read & ~squash_s;
            out_mem_write  <= mem_write & ~squash_s;
            out_mem_to_reg <= mem_to_reg;
            out_funct3     <= funct3;
            out_wdata      <= wdata_s;
            out_byte_en    <= squash_s ? 4'b0000 : be_s;
            out_misaligned <= mis_s;
            cnt_r          <= cnt_r + 32'h0000_0001;
        end
    end

    assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed self-checking bench for ex_mem_stage; expectations follow EX_MEM_MISALIGN_TRAP_EN when defined.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [31:0] alu_result, rs2_data;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic [2:0]  funct3;
    logic        out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, out_misaligned;
    logic [31:0] out_alu_result, out_wdata, retired_cnt;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [3:0]  out_byte_en;

    int tests_run    = 0;
    int tests_failed = 0;

    ex_mem_stage #(.DATA_WIDTH(32), .REG_ADDR(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_result(alu_result), .rs2_data(rs2_data), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .funct3(funct3), .out_valid(out_valid), .out_alu_result(out_alu_result), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_to_reg(out_mem_to_reg), .out_funct3(out_funct3), .out_wdata(out_wdata),
        .out_byte_en(out_byte_en), .out_misaligned(out_misaligned), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] r, input logic rw, input logic mr, input logic mw,
                          input logic m2r, input logic [2:0] f3);
        in_valid = v; alu_result = alu; rs2_data = rs2; rd = r;
        reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = m2r; funct3 = f3;
    endtask

    task automatic check_cleared(input string tag, input logic [31:0] cnt);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_alu"}, out_alu_result, 32'd0);
        check({tag, "_rd"}, {27'd0, out_rd}, 32'd0);
        check({tag, "_ctrl"}, {28'd0, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg}, 32'd0);
        check({tag, "_f3"}, {29'd0, out_funct3}, 32'd0);
        check({tag, "_wdata"}, out_wdata, 32'd0);
        check({tag, "_be"}, {28'd0, out_byte_en}, 32'd0);
        check({tag, "_mis"}, {31'd0, out_misaligned}, 32'd0);
        check({tag, "_cnt"}, retired_cnt, cnt);
    endtask

    initial begin
        stall = 1'b0; flush = 1'b0; reset = 1'b0;
        set_in(1'b1, 32'hCAFE_1233, 32'h5555_AAAA, 5'd17, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
        tick(); tick();
        check_cleared("reset", 32'd0);
        reset = 1'b1;

        // store byte at offset 3
        set_in(1'b1, 32'h0000_1003, 32'h0000_00AB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        tick();
        check("sb_wdata", out_wdata, 32'hABAB_ABAB);
        check("sb_be", {28'd0, out_byte_en}, 32'h8);
        check("sb_alu", out_alu_result, 32'h0000_1003);
        check("sb_ctrl", {28'd0, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg}, 32'h2);
        check("sb_valid", {31'd0, out_valid}, 32'd1);
        check("sb_cnt", retired_cnt, 32'd1);

        // store half at offset 2
        set_in(1'b1, 32'h0000_2002, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
        tick();
        check("sh_wdata", out_wdata, 32'h1234_1234);
        check("sh_be", {28'd0, out_byte_en}, 32'hC);
        check("sh_f3", {29'd0, out_funct3}, 32'd1);
        check("sh_cnt", retired_cnt, 32'd2);

        // store byte at offset 1
        set_in(1'b1, 32'h0000_4001, 32'h0000_005A, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        tick();
        check("sb1_be", {28'd0, out_byte_en}, 32'h2);
        check("sb1_wdata", out_wdata, 32'h5A5A_5A5A);

        // aligned word store
        set_in(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010);
        tick();
        check("sw_wdata", out_wdata, 32'hDEAD_BEEF);
        check("sw_be", {28'd0, out_byte_en}, 32'hF);
        check("sw_mis", {31'd0, out_misaligned}, 32'd0);
        check("sw_cnt", retired_cnt, 32'd4);

        // ALU op: no memory access, byte enables forced low
        set_in(1'b1, 32'h0000_0055, 32'h1122_3344, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        check("alu_be", {28'd0, out_byte_en}, 32'h0);
        check("alu_rd", {27'd0, out_rd}, 32'd7);
        check("alu_rw", {31'd0, out_reg_write}, 32'd1);
        check("alu_wdata", out_wdata, 32'h4444_4444);

        // unsigned halfword load, funct3[2] passed through
        set_in(1'b1, 32'h0000_0102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 3'b101);
        tick();
        check("lhu_be", {28'd0, out_byte_en}, 32'hC);
        check("lhu_f3", {29'd0, out_funct3}, 32'd5);
        check("lhu_m2r", {31'd0, out_mem_to_reg}, 32'd1);

        // load rd=5, then stall three cycles with changing inputs
        set_in(1'b1, 32'h0000_0100, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
        tick();
        check("ld_rd", {27'd0, out_rd}, 32'd5);
        check("ld_cnt", retired_cnt, 32'd7);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h0000_9000 + i, 32'h7777_0000 + i, 5'd9 + 5'(i), 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
            tick();
            check("stall_rd", {27'd0, out_rd}, 32'd5);
            check("stall_alu", out_alu_result, 32'h0000_0100);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_cnt", retired_cnt, 32'd7);
        end
        flush = 1'b1;
        tick();
        check_cleared("flush", 32'd7);
        stall = 1'b0; flush = 1'b0;

        // release: current inputs load
        set_in(1'b1, 32'h0000_0200, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        check("rel_rd", {27'd0, out_rd}, 32'd3);
        check("rel_cnt", retired_cnt, 32'd8);

        // invalid load acts as bubble, counter holds
        set_in(1'b0, 32'h0000_0300, 32'h1234_5678, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010);
        tick();
        check_cleared("bubble", 32'd8);

        // misaligned word load
        set_in(1'b1, 32'h0000_1001, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
        tick();
        check("mis_valid", {31'd0, out_valid}, 32'd1);
        check("mis_alu", out_alu_result, 32'h0000_1001);
        check("mis_cnt", retired_cnt, 32'd9);
`ifdef EX_MEM_MISALIGN_TRAP_EN
        check("mis_flag", {31'd0, out_misaligned}, 32'd1);
        check("mis_mr", {31'd0, out_mem_read}, 32'd0);
        check("mis_rw", {31'd0, out_reg_write}, 32'd0);
        check("mis_be", {28'd0, out_byte_en}, 32'h0);
`else
        check("mis_flag", {31'd0, out_misaligned}, 32'd0);
        check("mis_mr", {31'd0, out_mem_read}, 32'd1);
        check("mis_rw", {31'd0, out_reg_write}, 32'd1);
        check("mis_be", {28'd0, out_byte_en}, 32'hF);
`endif

        // misaligned half store and illegal size 11
        set_in(1'b1, 32'h0000_2003, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
        tick();
`ifdef EX_MEM_MISALIGN_TRAP_EN
        check("mish_be", {28'd0, out_byte_en}, 32'h0);
        check("mish_flag", {31'd0, out_misaligned}, 32'd1);
`else
        check("mish_be", {28'd0, out_byte_en}, 32'hC);
        check("mish_flag", {31'd0, out_misaligned}, 32'd0);
`endif
        set_in(1'b1, 32'h0000_2000, 32'hA1B2_C3D4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011);
        tick();
        check("f3_11_wdata", out_wdata, 32'hA1B2_C3D4);
`ifdef EX_MEM_MISALIGN_TRAP_EN
        check("f3_11_be", {28'd0, out_byte_en}, 32'h0);
        check("f3_11_mw", {31'd0, out_mem_write}, 32'd0);
`else
        check("f3_11_be", {28'd0, out_byte_en}, 32'hF);
        check("f3_11_mw", {31'd0, out_mem_write}, 32'd1);
`endif
        check("f3_11_cnt", retired_cnt, 32'd11);

        // reset wins over stall
        stall = 1'b1; reset = 1'b0;
        tick();
        check_cleared("rst_stall", 32'd0);
        stall = 1'b0; reset = 1'b1;

        // counter wrap
        force dut.cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_r;
        set_in(1'b1, 32'h0000_0010, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        check("wrap_cnt", retired_cnt, 32'h0000_0000);
        check("wrap_valid", {31'd0, out_valid}, 32'd1);
        set_in(1'b0, 32'h0000_0020, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        check("wrap_hold", retired_cnt, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
